// File: rtl/camera_pkg.sv
// Shared types and constants for the camera parameter bank (Q7.20 fixed point, state encoding).
// Defines parameter indices, reset defaults and the load/pending/publish state enum.
package camera_pkg;

   localparam int QW         = 27;
   localparam int NUM_PARAMS = 12;

   localparam logic [3:0] IDX_EYE_X    = 4'd0;
   localparam logic [3:0] IDX_EYE_Y    = 4'd1;
   localparam logic [3:0] IDX_EYE_Z    = 4'd2;
   localparam logic [3:0] IDX_LA_1_1   = 4'd3;
   localparam logic [3:0] IDX_LA_1_2   = 4'd4;
   localparam logic [3:0] IDX_LA_1_3   = 4'd5;
   localparam logic [3:0] IDX_LA_2_1   = 4'd6;
   localparam logic [3:0] IDX_LA_2_2   = 4'd7;
   localparam logic [3:0] IDX_LA_2_3   = 4'd8;
   localparam logic [3:0] IDX_LA_3_1   = 4'd9;
   localparam logic [3:0] IDX_LA_3_2   = 4'd10;
   localparam logic [3:0] IDX_LA_3_3   = 4'd11;

   localparam logic [QW-1:0] Q_ZERO    = 27'h0000000;
   localparam logic [QW-1:0] Q_ONE     = 27'h0100000;
   localparam logic [QW-1:0] EYE_Z_RST = 27'h7C00000;   // -4.0

   typedef enum logic [1:0] {
      ST_LOAD    = 2'd0,
      ST_PENDING = 2'd1,
      ST_PUBLISH = 2'd2
   } state_t;

   // Camera starts four units back on -z looking through an identity basis.
   function automatic logic [QW-1:0] param_default(input logic [3:0] idx);
      case (idx)
         IDX_EYE_Z:                          return EYE_Z_RST;
         IDX_LA_1_1, IDX_LA_2_2, IDX_LA_3_3: return Q_ONE;
         default:                            return Q_ZERO;
      endcase
   endfunction

endpackage

// File: rtl/camera_param_bank.sv
// Double-buffered camera parameters: HPS writes a shadow bank, a commit publishes all 12 atomically
// frame_start+2 cycles later; wr_ready drops while a commit is pending. Optional CAMERA_PARAM_READBACK_EN.
module camera_param_bank
   import camera_pkg::*;
(
   input  logic          clk,
   input  logic          reset_n,
   input  logic          wr_valid,
   output logic          wr_ready,
   input  logic [3:0]    wr_addr,
   input  logic [QW-1:0] wr_data,
   input  logic          commit_req,
   input  logic          frame_start,
`ifdef CAMERA_PARAM_READBACK_EN
   input  logic [3:0]    rd_addr,
   output logic [QW-1:0] rd_data,
`endif
   output logic [QW-1:0] eye_x,
   output logic [QW-1:0] eye_y,
   output logic [QW-1:0] eye_z,
   output logic [QW-1:0] look_at_1_1,
   output logic [QW-1:0] look_at_1_2,
   output logic [QW-1:0] look_at_1_3,
   output logic [QW-1:0] look_at_2_1,
   output logic [QW-1:0] look_at_2_2,
   output logic [QW-1:0] look_at_2_3,
   output logic [QW-1:0] look_at_3_1,
   output logic [QW-1:0] look_at_3_2,
   output logic [QW-1:0] look_at_3_3,
   output logic          commit_pending,
   output logic          param_update,
   output logic          wr_err
);

   state_t        state;
   logic [QW-1:0] shadow [NUM_PARAMS];
   logic [QW-1:0] active [NUM_PARAMS];
   logic          addr_ok;
   logic          wr_fire;

   assign addr_ok = (wr_addr < 4'(NUM_PARAMS));
   assign wr_fire = wr_valid && wr_ready;

   // wr_ready is held low through the first cycle out of reset and whenever the shadow is locked.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state          <= ST_LOAD;
         wr_ready       <= 1'b0;
         commit_pending <= 1'b0;
         param_update   <= 1'b0;
         wr_err         <= 1'b0;
      end else begin
         param_update <= 1'b0;
         wr_err       <= wr_fire && !addr_ok;
         case (state)
            ST_LOAD: begin
               if (commit_req) begin
                  state          <= ST_PENDING;
                  wr_ready       <= 1'b0;
                  commit_pending <= 1'b1;
               end else begin
                  wr_ready <= 1'b1;
               end
            end
            ST_PENDING: begin
               if (frame_start) begin
                  state <= ST_PUBLISH;
               end
            end
            ST_PUBLISH: begin
               state          <= ST_LOAD;
               wr_ready       <= 1'b1;
               commit_pending <= 1'b0;
               param_update   <= 1'b1;
            end
            default: begin
               state          <= ST_LOAD;
               wr_ready       <= 1'b0;
               commit_pending <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_PARAMS; i++) begin
            shadow[i] <= param_default(4'(i));
            active[i] <= param_default(4'(i));
         end
      end else begin
         if (wr_fire && addr_ok) begin
            shadow[wr_addr] <= wr_data;
         end
         if (state == ST_PUBLISH) begin
            for (int i = 0; i < NUM_PARAMS; i++) begin
               active[i] <= shadow[i];
            end
         end
      end
   end

`ifdef CAMERA_PARAM_READBACK_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_data <= Q_ZERO;
      end else begin
         rd_data <= (rd_addr < 4'(NUM_PARAMS)) ? shadow[rd_addr] : Q_ZERO;
      end
   end
`endif

   assign eye_x       = active[IDX_EYE_X];
   assign eye_y       = active[IDX_EYE_Y];
   assign eye_z       = active[IDX_EYE_Z];
   assign look_at_1_1 = active[IDX_LA_1_1];
   assign look_at_1_2 = active[IDX_LA_1_2];
   assign look_at_1_3 = active[IDX_LA_1_3];
   assign look_at_2_1 = active[IDX_LA_2_1];
   assign look_at_2_2 = active[IDX_LA_2_2];
   assign look_at_2_3 = active[IDX_LA_2_3];
   assign look_at_3_1 = active[IDX_LA_3_1];
   assign look_at_3_2 = active[IDX_LA_3_2];
   assign look_at_3_3 = active[IDX_LA_3_3];

endmodule
